// File: rtl/dc_motor_axil_regs.sv
// AXI4-Lite slave with four 32-bit registers (CTRL, PERIOD, DUTY, SCRATCH)
// driving a shadowed 16-bit PWM generator plus motor direction/enable pins.
module dc_motor_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            motor_pwm,
  output logic                            motor_dir,
  output logic                            motor_en
);

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  wstate_t     wstate_q, wstate_d;
  rstate_t     rstate_q, rstate_d;
  logic [31:0] regs_q [4];
  logic [31:0] rdata_q, rdata_d;
  logic        wr_acc, rd_acc;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] per_act_q, per_act_d;
  logic [15:0] duty_act_q, duty_act_d;
  logic        en, wrap, per_zero;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  // Both READYs rise together, combinationally, only once AW and W are both valid.
  always_comb begin
    wstate_d = wstate_q;
    wr_acc   = 1'b0;
    case (wstate_q)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID && !ARESET) begin
        wr_acc   = 1'b1;
        wstate_d = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rd_acc   = 1'b0;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: if (S_AXI_ARVALID && !ARESET) begin
        rd_acc   = 1'b1;
        rstate_d = R_DATA;
        rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
      end
      R_DATA: if (S_AXI_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      if (wr_acc)
        regs_q[S_AXI_AWADDR[3:2]] <= apply_strb(regs_q[S_AXI_AWADDR[3:2]], S_AXI_WDATA, S_AXI_WSTRB);
    end
  end

  // PWM: shadows reload on wrap or while the active period is zero.
  always_comb begin
    en         = regs_q[0][0];
    per_zero   = (per_act_q == 16'd0);
    wrap       = en && !per_zero && (cnt_q == per_act_q - 16'd1);
    cnt_d      = cnt_q + 16'd1;
    if (!en || per_zero || wrap) cnt_d = 16'd0;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    if (wrap || per_zero) begin
      per_act_d  = regs_q[1][15:0];
      duty_act_d = regs_q[2][15:0];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q      <= '0;
      per_act_q  <= '0;
      duty_act_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
    end
  end

  assign S_AXI_AWREADY = wr_acc;
  assign S_AXI_WREADY  = wr_acc;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = rd_acc;
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign motor_en      = en;
  assign motor_dir     = regs_q[0][1];
  assign motor_pwm     = en && !per_zero && (cnt_q < duty_act_q);

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                    regs_q[1][31:16], regs_q[2][31:16]};

endmodule

// File: tb/tb_dc_motor_axil_regs.sv
// Directed bench for dc_motor_axil_regs: AXI-Lite register access, handshakes,
// PWM shadowing/boundaries and mid-transaction reset.
module tb_dc_motor_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  AWADDR = '0, ARADDR = '0;
  logic [2:0]  AWPROT = '0, ARPROT = '0;
  logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        motor_pwm, motor_dir, motor_en;

  int n_chk = 0;
  int n_pass = 0;

  dc_motor_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .motor_pwm(motor_pwm), .motor_dir(motor_dir), .motor_en(motor_en)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge ACLK);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1; WVALID = 1;
    #1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin
      @(negedge ACLK); #1; n++;
    end
    check("wr_accept", 32'(n < 20), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    check("wr_bvalid", 32'(BVALID), 32'd1);
    check("wr_bresp", 32'(BRESP), 32'd0);
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    check("wr_bvalid_clr", 32'(BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin
      @(negedge ACLK); #1; n++;
    end
    check("rd_accept", 32'(n < 20), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 0;
    check("rd_rvalid", 32'(RVALID), 32'd1);
    check("rd_rresp", 32'(RRESP), 32'd0);
    data = RDATA;
    RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0;
    check("rd_rvalid_clr", 32'(RVALID), 32'd0);
  endtask

  // Returns on the negedge where motor_pwm first reads high after being low.
  task automatic wait_rise();
    int k;
    logic p, found;
    k = 0; found = 0;
    @(negedge ACLK);
    p = motor_pwm;
    while (!found && k < 40) begin
      @(negedge ACLK);
      k++;
      found = motor_pwm && !p;
      p = motor_pwm;
    end
    check("pwm_rise_seen", 32'(found), 32'd1);
  endtask

  // Bit i = motor_pwm at the i-th negedge, starting with the current one.
  task automatic sample(input int len, output logic [31:0] bits);
    bits = '0;
    for (int i = 0; i < len; i++) begin
      bits[i] = motor_pwm;
      if (i < len - 1) @(negedge ACLK);
    end
  endtask

  logic [31:0] rd, bits;

  initial begin
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_motor", {29'd0, motor_pwm, motor_dir, motor_en}, 32'd0);
    ARESET = 0;

    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'h0, rd); check("vip_rd0", rd, 32'h1);
    axi_read(4'h4, rd); check("vip_rd1", rd, 32'h2);
    axi_read(4'h8, rd); check("vip_rd2", rd, 32'h3);
    axi_read(4'hC, rd); check("vip_rd3", rd, 32'h4);
    axi_read(4'hE, rd); check("addr_lsb_ignored", rd, 32'h4);

    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    axi_write(4'hC, 32'h0000_0000, 4'b0101);
    axi_read(4'hC, rd); check("wstrb_merge", rd, 32'hFF00_FF00);

    // AW leads W by 3 cycles; BREADY held low 5 cycles with new request pending.
    @(negedge ACLK);
    AWADDR = 4'hC; WDATA = 32'h1234_5678; WSTRB = 4'hF; AWVALID = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("aw_only_awready", 32'(AWREADY), 32'd0);
      check("aw_only_wready", 32'(WREADY), 32'd0);
      @(negedge ACLK);
    end
    WVALID = 1;
    #1;
    check("both_awready", 32'(AWREADY), 32'd1);
    check("both_wready", 32'(WREADY), 32'd1);
    @(posedge ACLK); #1;
    WDATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("bvalid_hold", 32'(BVALID), 32'd1);
      check("no_second_accept", 32'(AWREADY | WREADY), 32'd0);
      @(posedge ACLK); #1;
    end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    check("bvalid_released", 32'(BVALID), 32'd0);
    axi_read(4'hC, rd); check("hs_readback", rd, 32'h1234_5678);

    // PWM 10/3 with CTRL already enabled.
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h4, 32'd10, 4'hF);
    wait_rise();
    sample(20, bits); check("pwm_10_3", bits, 32'h0000_1C07);

    wait_rise();
    axi_write(4'h8, 32'd7, 4'hF);
    check("duty_mid_period_hold", 32'(motor_pwm), 32'd0);
    wait_rise();
    sample(10, bits); check("pwm_10_7", bits, 32'h0000_007F);

    axi_write(4'h8, 32'd12, 4'hF);
    repeat (25) @(negedge ACLK);
    sample(20, bits); check("pwm_duty_ge_period", bits, 32'h000F_FFFF);

    axi_write(4'h4, 32'd0, 4'hF);
    repeat (15) @(negedge ACLK);
    sample(20, bits); check("pwm_period_zero", bits, 32'h0);

    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h0, 32'h0, 4'hF);
    check("ctrl0_en", 32'(motor_en), 32'd0);
    repeat (5) @(negedge ACLK);
    sample(20, bits); check("pwm_disabled", bits, 32'h0);

    axi_write(4'h0, 32'h3, 4'hF);
    check("ctrl3_en", 32'(motor_en), 32'd1);
    check("ctrl3_dir", 32'(motor_dir), 32'd1);
    check("ctrl3_pwm", 32'(motor_pwm), 32'd1);
    @(negedge ACLK);
    sample(10, bits); check("pwm_restart_from_0", bits, 32'h0000_0203);

    // Reset while BVALID pending and PWM running.
    @(negedge ACLK);
    AWADDR = 4'h8; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    check("rst_pre_bvalid", 32'(BVALID), 32'd1);
    #2 ARESET = 1;
    #1;
    check("arst_bvalid", 32'(BVALID), 32'd0);
    check("arst_motor", {29'd0, motor_pwm, motor_dir, motor_en}, 32'd0);
    check("arst_rvalid", 32'(RVALID), 32'd0);
    @(negedge ACLK);
    ARESET = 0;
    axi_read(4'h0, rd); check("arst_ctrl", rd, 32'h0);
    axi_read(4'h8, rd); check("arst_duty", rd, 32'h0);
    axi_read(4'hC, rd); check("arst_scratch", rd, 32'h0);
    axi_write(4'h4, 32'hA5, 4'hF);
    axi_read(4'h4, rd); check("post_rst_rw", rd, 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dc_motor_axil_regs.md
# dc_motor_axil_regs

AXI4-Lite slave register bank and PWM generator for the DC motor peripheral. It is the responder that bus masters, including the AXI VIP master in the block's BFM bench, drive through `AXI4LITE_WRITE_BURST` / `AXI4LITE_READ_BURST`. It holds four 32-bit read/write registers and drives the motor PWM, direction and enable pins from them.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 word registers at 0x0/0x4/0x8/0xC
- ACLK  in  1  single clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  4  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake
- S_AXI_BRESP  out  2  always 2'b00 (OKAY)
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake
- S_AXI_ARADDR  in  4  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always 2'b00
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake
- motor_pwm  out  1  PWM drive
- motor_dir  out  1  direction (CTRL[1])
- motor_en  out  1  driver enable (CTRL[0])

## Operation
- Registers, all fully R/W: reg0 CTRL (bit0 enable, bit1 dir; remaining bits stored, no effect); reg1 PERIOD (bits[15:0] used); reg2 DUTY (bits[15:0] used); reg3 SCRATCH (no effect).
- Address decode uses AWADDR[3:2] / ARADDR[3:2]; bits [1:0] ignored.
- Write: WSTRB[n] gates byte n; unstrobed bytes keep old value.
- Write FSM: IDLE -> (AWVALID && WVALID && !BVALID) assert AWREADY and WREADY together for exactly one cycle and commit the register -> RESP (BVALID=1) -> on BREADY go to IDLE. AW without W, or W without AW, waits; neither READY is raised alone.
- Read FSM: IDLE -> (ARVALID && !RVALID) assert ARREADY for one cycle and latch RDATA -> RVALID=1 held with stable RDATA until RREADY -> IDLE.
- Read and write channels are independent and may complete in the same cycle. A read accepted in the same cycle as a write to the same register returns the pre-write value.
- PWM: 16-bit counter counts 0..PERIOD_act-1 and wraps. motor_pwm = motor_en && (cnt < DUTY_act).
  - PERIOD_act and DUTY_act are shadow copies, loaded from reg1/reg2 when cnt wraps to 0, or whenever PERIOD_act==0.
  - PERIOD_act==0: counter held at 0, motor_pwm=0.
  - DUTY_act >= PERIOD_act (nonzero): motor_pwm constant 1 while enabled.
  - motor_en=0: counter held at 0, motor_pwm=0.
- motor_dir and motor_en follow CTRL with no shadowing.

## Timing
- Reset (asynchronous assert, released synchronously to ACLK): all registers, shadows and counter = 0; AWREADY=WREADY=ARREADY=BVALID=RVALID=0; RDATA=0; motor_pwm=motor_dir=motor_en=0.
- ARESET mid-transaction aborts it: VALIDs and READYs drop immediately and no response is issued.
- Write latency: AW/W accepted in cycle N; register updated and BVALID=1 at edge N+1; readback shows the new value for any read accepted from N+1.
- Read latency: AR accepted in cycle N; RVALID=1 with data at edge N+1.
- Back-to-back throughput: one transaction per 2 cycles per channel when BREADY/RREADY are held high.
- CTRL write propagates to motor_en/motor_dir 1 cycle after the write handshake.
- PERIOD/DUTY writes take effect at the next counter wrap.

## Test plan
- VIP sequence: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four back -> reads return 0x1,0x2,0x3,0x4; all BRESP/RRESP = OKAY.
- Byte strobes: write 0xFFFFFFFF to 0xC, then 0x00000000 with WSTRB=4'b0101 -> readback 0xFF00FF00.
- Handshake ordering: AWVALID asserted 3 cycles before WVALID, and BREADY held low for 5 cycles -> AWREADY/WREADY pulse together once both are valid; BVALID stays high until BREADY; no second accept occurs meanwhile.
- PWM: PERIOD=10, DUTY=3, CTRL=0x1 -> motor_pwm high 3 / low 7 cycles, repeating. Changing DUTY to 7 mid-period takes effect from the next wrap. DUTY=12 -> constant high. PERIOD=0 -> constant low.
- CTRL=0x3 -> motor_en=1, motor_dir=1. CTRL=0x0 -> motor_pwm=0 and counter held at 0.
- ARESET pulse while BVALID is pending and PWM is running -> all outputs and registers read 0 afterwards; the next write/read completes normally.
